// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, with a carry register between digits.
// Operands and results move through valid/ready handshakes; adds signed-overflow and zero flags.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [DIGIT-1:0] w_sum;
  logic             w_c_msb_in;
  logic             w_c_out;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_accept;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == CW'(NDIG - 1));
  assign w_acc_next = WIDTH'({w_sum, r_acc} >> DIGIT);

  // Ripple chain over one digit; the carry into the top cell is kept for ovf.
  always_comb begin
    logic v_c;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_sum      = '0;
    w_c_msb_in = 1'b0;
    v_c        = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) w_c_msb_in = v_c;
      w_sum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c      = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_c_out = v_c;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_next_state = BUSY;
      BUSY:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          // Subtraction is a + ~b + ~borrow_in.
          r_a     <= a;
          r_b     <= b ^ {WIDTH{sub}};
          r_carry <= sub ? ~cin : cin;
          r_cnt   <= '0;
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_carry <= w_c_out;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_s    <= w_acc_next;
            r_cout <= w_c_out;
            r_ovf  <= w_c_msb_in ^ w_c_out;
            r_zero <= (w_acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
